eth_tx_serializer: RTL and testbench
====================================

ETH_TX_SERIALIZER -- requirements
Module: eth_tx_serializer

Interface
REQ-001 SHALL have parameter MIN_FRAME, default 60, minimum bytes (destination address through padding, FCS excluded) per frame.
REQ-002 SHALL have parameter IFG_BITS, default 96, idle bit-times after each FCS.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tx_data  in  8  frame byte (destination MAC first), valid with tx_valid.
REQ-006 tx_valid  in  1  upstream has a byte.
REQ-007 tx_last  in  1  qualifies tx_data as final byte of frame.
REQ-008 tx_ready  out  1  byte accepted on any cycle with tx_valid&tx_ready.
REQ-009 bit_out  out  1  serial line bit.
REQ-010 bit_en  out  1  bit_out is a live frame bit this cycle.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 tx_underrun  out  1  one-cycle pulse on frame abort.

Function
REQ-013 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG; one line bit per clk in all non-IDLE states.
REQ-014 IDLE: tx_ready=0; tx_valid=1 -> PREAMBLE next cycle; tx_data not consumed.
REQ-015 PREAMBLE: 56 cycles, bit_en=1, bit_out alternating 1,0,... starting with 1 (7 x 0x55 LSB first).
REQ-016 SFD: 8 cycles, byte 0xD5 LSB first (1,0,1,0,1,0,1,1); tx_ready=1 on the 8th cycle only; CRC register loads 0xFFFFFFFF during SFD.
REQ-017 Missing tx_valid on any cycle tx_ready=1 SHALL abort: tx_underrun pulse that cycle, bit_en=0 next cycle, go to IFG, no FCS.
REQ-018 DATA: each accepted byte sent LSB first over 8 cycles starting the cycle after acceptance; tx_ready=1 on the 8th bit of a byte unless that byte had tx_last=1 (gap-free bytes).
REQ-019 After last byte: byte count < MIN_FRAME -> PAD (0x00 bytes until count = MIN_FRAME), else -> FCS.
REQ-020 Byte counter SHALL be 11 bits and saturate at 2047; no maximum-length enforcement.
REQ-021 CRC per DATA/PAD bit d: fb=c[31]^d; c={c[30:0],1'b0} ^ (fb ? 0x04C11DB7 : 0).
REQ-022 FCS: 32 cycles, bit_out = ~c[31], ~c[30], ..., ~c[0] of CRC after final pad/data bit.
REQ-023 IFG: IFG_BITS cycles, bit_en=0, bit_out=0; then IDLE; tx_valid during IFG SHALL be ignored.
REQ-024 Frame of N bytes: bit_en high exactly 64+8*max(N,MIN_FRAME)+32 consecutive cycles, first high cycle = cycle after tx_valid seen in IDLE.
REQ-025 bit_en=0 and bit_out=0 in IDLE and IFG.

Reset
REQ-026 reset SHALL force IDLE, tx_ready=0, bit_out=0, bit_en=0, busy=0, tx_underrun=0, counters 0, CRC 0xFFFFFFFF, next cycle.
REQ-027 reset mid-frame SHALL drop the frame without FCS and without IFG; first cycle after deassert is IDLE.

Structure
REQ-028 eth_pkg SHALL hold the state enum, CRC_POLY=0x04C11DB7, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xC704DD7B, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5.
REQ-029 CRC SHALL sit in sub-module eth_tx_crc32 (clk, reset, init, en, d, crc[31:0]); FSM, shifter and counters in the top.

Verification
REQ-030 42-byte ARP request ff ff ff ff ff ff 98 5a eb dd 1c 64 08 06 00 01 08 00 06 04 00 01 98 5a eb dd 1c 64 c0 a8 02 02 00 00 00 00 00 00 9d 37 eb 91 -> 18 pad bytes 0x00, FCS bytes on line f1 ff 34 21, bit_en high 576 cycles.
REQ-031 4-byte frame 41 42 43 44 -> 56 zero pad bytes, 576 bit_en cycles; CRC over all bits after SFD through FCS (re-run with c, no final complement) = 0xC704DD7B.
REQ-032 100-byte frame, tx_valid held -> no PAD, 896 bit_en cycles, tx_ready pulses exactly 100 times, residue 0xC704DD7B.
REQ-033 tx_valid dropped when tx_ready=1 at byte 10 -> tx_underrun one pulse, bit_en low next cycle, busy low after 96 cycles.
REQ-034 reset asserted in DATA for one cycle -> all outputs 0 next cycle; following 60-byte frame transmits correctly.
REQ-035 Two back-to-back frames, tx_valid held high -> exactly 96 bit_en=0 cycles between first FCS end and second preamble, plus 1 IDLE cycle.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit serializer.
package eth_pkg;

    // Line states of the transmitter
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6
    } eth_state_e;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Bit counter covers preamble (56) and IFG lengths up to 65535.
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned BYTE_CNT_W    = 11;

    // One serial CRC-32 step: MSB-first shift register fed one line bit.
    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic d);
        logic fb;
        fb = c[31] ^ d;
        if (fb) begin
            return {c[30:0], 1'b0} ^ CRC_POLY;
        end else begin
            return {c[30:0], 1'b0};
        end
    endfunction

    // Byte counter increment that sticks at its maximum value.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc11(input logic [BYTE_CNT_W-1:0] v);
        if (v == 11'h7FF) begin
            return v;
        end else begin
            return v + 11'd1;
        end
    endfunction

endpackage

// File: rtl/eth_tx_crc32.sv
// Serial CRC-32 accumulator: one bit per enabled clock, reloads on init.
module eth_tx_crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        d,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC value: reload, advance by one bit, or hold.
    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc32_step(crc_q, d);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register with synchronous reset to the seed value.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/eth_tx_serializer.sv
// Ethernet frame serializer: preamble, SFD, data, zero padding, FCS and
// inter-frame gap on a one-bit-per-clock line, with byte handshake upstream.
module eth_tx_serializer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 60,
    parameter int unsigned IFG_BITS  = 96
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       bit_out,
    output logic       bit_en,
    output logic       busy,
    output logic       tx_underrun
);

    localparam logic [CNT_W-1:0]      PRE_LAST  = 16'd55;
    localparam logic [CNT_W-1:0]      BYTE_LAST = 16'd7;
    localparam logic [CNT_W-1:0]      FCS_LAST  = 16'd31;
    localparam logic [CNT_W-1:0]      IFG_LAST  = CNT_W'(IFG_BITS - 1);
    localparam logic [BYTE_CNT_W-1:0] MIN_BYTES = BYTE_CNT_W'(MIN_FRAME);

    eth_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  last_q, last_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

    logic                  crc_init_s;
    logic                  crc_en_s;
    logic [31:0]           crc_s;

    // Next-state, line bit and handshake decode for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        shreg_d     = shreg_q;
        last_d      = last_q;
        byte_cnt_d  = byte_cnt_q;
        tx_ready    = 1'b0;
        tx_underrun = 1'b0;
        bit_out     = 1'b0;
        bit_en      = 1'b0;
        crc_init_s  = 1'b0;
        crc_en_s    = 1'b0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                cnt_d      = 16'd0;
                byte_cnt_d = 11'd0;
                if (tx_valid) begin
                    state_d = ST_PREAMBLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PREAMBLE: begin
                bit_en  = 1'b1;
                bit_out = PREAMBLE_BYTE[cnt_q[2:0]];
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_PREAMBLE;
                end
            end

            ST_SFD: begin
                bit_en     = 1'b1;
                bit_out    = SFD_BYTE[cnt_q[2:0]];
                crc_init_s = 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    // First byte must be waiting on the final SFD bit.
                    tx_ready = 1'b1;
                    cnt_d    = 16'd0;
                    if (tx_valid) begin
                        shreg_d    = tx_data;
                        last_d     = tx_last;
                        byte_cnt_d = sat_inc11(byte_cnt_q);
                        state_d    = ST_DATA;
                    end else begin
                        tx_underrun = 1'b1;
                        state_d     = ST_IFG;
                    end
                end else begin
                    state_d = ST_SFD;
                end
            end

            ST_DATA: begin
                bit_en   = 1'b1;
                bit_out  = shreg_q[cnt_q[2:0]];
                crc_en_s = 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    cnt_d = 16'd0;
                    if (last_q) begin
                        if (byte_cnt_q < MIN_BYTES) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d = ST_FCS;
                        end
                    end else begin
                        // Next byte is taken while the current one finishes,
                        // so consecutive bytes leave no gap on the line.
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            shreg_d    = tx_data;
                            last_d     = tx_last;
                            byte_cnt_d = sat_inc11(byte_cnt_q);
                            state_d    = ST_DATA;
                        end else begin
                            tx_underrun = 1'b1;
                            state_d     = ST_IFG;
                        end
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_PAD: begin
                bit_en   = 1'b1;
                bit_out  = 1'b0;
                crc_en_s = 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    cnt_d      = 16'd0;
                    byte_cnt_d = sat_inc11(byte_cnt_q);
                    if (sat_inc11(byte_cnt_q) >= MIN_BYTES) begin
                        state_d = ST_FCS;
                    end else begin
                        state_d = ST_PAD;
                    end
                end else begin
                    state_d = ST_PAD;
                end
            end

            ST_FCS: begin
                // CRC is frozen here; send it complemented, MSB first.
                bit_en  = 1'b1;
                bit_out = ~crc_s[~cnt_q[4:0]];
                if (cnt_q == FCS_LAST) begin
                    state_d = ST_IFG;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_FCS;
                end
            end

            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IFG;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // Sequencer registers; reset drops any frame in flight straight to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            shreg_q    <= 8'd0;
            last_q     <= 1'b0;
            byte_cnt_q <= 11'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    eth_tx_crc32 u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init_s),
        .en    (crc_en_s),
        .d     (bit_out),
        .crc   (crc_s)
    );

endmodule

// File: tb/tb_eth_tx_serializer.sv
// Directed bench for eth_tx_serializer with a frame-level reference model.
module tb_eth_tx_serializer;

    localparam int MF  = 60;
    localparam int IFG = 96;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       bit_out;
    logic       bit_en;
    logic       busy;
    logic       tx_underrun;

    int checks   = 0;
    int failures = 0;

    logic [4:0] exp_q[$];   // per-cycle {bit_en, bit_out, busy, tx_ready, tx_underrun}
    logic       cap_q[$];   // line bits captured while bit_en is high
    logic [7:0] fb[$];      // bytes of the frame being sent
    int en_cnt, rdy_cnt, und_cnt;
    int zero_run = 0;
    int last_gap = 0;

    always #5 clk = ~clk;

    eth_tx_serializer #(.MIN_FRAME(MF), .IFG_BITS(IFG)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .bit_out     (bit_out),
        .bit_en      (bit_en),
        .busy        (busy),
        .tx_underrun (tx_underrun)
    );

    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic d);
        logic fbk;
        fbk = c[31] ^ d;
        c   = {c[30:0], 1'b0};
        if (fbk) c = c ^ 32'h04C11DB7;
        return c;
    endfunction

    // Bytes accepted strictly before cycle k (k = 0 is the IDLE cycle).
    function automatic int acc(input int k, input int n);
        int a;
        if (k <= 64) return 0;
        a = (k - 65) / 8 + 1;
        return (a > n) ? n : a;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // One clock: compare at the falling edge, then step past the rising edge.
    task automatic tick();
        logic [4:0] act;
        logic [4:0] ex;
        @(negedge clk);
        act = {bit_en, bit_out, busy, tx_ready, tx_underrun};
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            checks++;
            if (act !== ex) begin
                failures++;
                $display("FAIL cycle t=%0t {en,out,busy,rdy,und}: got %b, want %b", $time, act, ex);
            end
        end
        if (bit_en) begin
            en_cnt++;
            cap_q.push_back(bit_out);
            if (zero_run > 0) last_gap = zero_run;
            zero_run = 0;
        end else begin
            zero_run++;
        end
        if (tx_ready)    rdy_cnt++;
        if (tx_underrun) und_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Send fb[0..n-1]; drop >= 0 withholds byte 'drop'; rst_at >= 0 pulses reset.
    task automatic run_frame(input int n, input int drop, input int rst_at,
                             input int exp_en, input int exp_rdy, input int exp_und,
                             input bit chk_res, input bit chk_arp);
        logic        bits_q[$];
        logic [31:0] c;
        logic [7:0]  b;
        logic [7:0]  sfd;
        logic [31:0] fcs_line;
        int m, full, live, idx, k, sz;

        m    = (n > MF) ? n : MF;
        full = 96 + 8 * m;
        live = (drop >= 0) ? 64 + 8 * drop : full;

        for (int i = 0; i < 56; i++) bits_q.push_back((i % 2) == 0);
        sfd = 8'hD5;
        for (int j = 0; j < 8; j++) bits_q.push_back(sfd[j]);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < m; i++) begin
            b = (i < n) ? fb[i] : 8'h00;
            for (int j = 0; j < 8; j++) begin
                bits_q.push_back(b[j]);
                c = crc_bit(c, b[j]);
            end
        end
        for (int j = 31; j >= 0; j--) bits_q.push_back(~c[j]);

        if (chk_arp) begin
            fcs_line = 32'd0;
            for (int j = 0; j < 32; j++) fcs_line[31 - 8 * (j / 8) - 7 + (j % 8)] = bits_q[64 + 8 * m + j];
            check32("model_arp_fcs_bytes", fcs_line, 32'hF1FF3421);
        end
        if (chk_res) begin
            c = 32'hFFFFFFFF;
            for (int i = 64; i < full; i++) c = crc_bit(c, bits_q[i]);
            check32("model_residue", c, eth_pkg::CRC_RESIDUE);
        end

        exp_q.push_back(5'b00000);
        for (int kk = 1; kk <= live; kk++) begin
            logic r;
            logic u;
            r = (kk >= 64) && ((kk - 64) % 8 == 0) && ((kk - 64) / 8 < n);
            u = (drop >= 0) && (kk == 64 + 8 * drop);
            exp_q.push_back({1'b1, bits_q[kk - 1], 1'b1, r, u});
        end
        for (int kk = 0; kk < IFG; kk++) exp_q.push_back(5'b00100);
        if (rst_at >= 0) begin
            while (exp_q.size() > rst_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(5'b00000);
        end

        cap_q.delete();
        en_cnt  = 0;
        rdy_cnt = 0;
        und_cnt = 0;
        sz = exp_q.size();
        for (k = 0; k < sz; k++) begin
            idx      = acc(k, n);
            reset    = (k == rst_at);
            tx_valid = 1'b1;
            if (rst_at >= 0 && k > rst_at)           tx_valid = 1'b0;
            if (drop >= 0 && k >= 64 + 8 * drop)     tx_valid = 1'b0;
            tx_data  = (idx < n) ? fb[idx] : 8'h00;
            tx_last  = (idx == n - 1);
            tick();
        end
        reset = 1'b0;

        check32("bit_en_cycles", en_cnt, exp_en);
        check32("tx_ready_pulses", rdy_cnt, exp_rdy);
        check32("underrun_pulses", und_cnt, exp_und);
        if (chk_res) begin
            c = 32'hFFFFFFFF;
            for (int i = 64; i < cap_q.size(); i++) c = crc_bit(c, cap_q[i]);
            check32("line_residue", c, RESIDUE);
        end
        if (chk_arp) begin
            fcs_line = 32'd0;
            sz = cap_q.size();
            for (int j = 0; j < 32; j++) fcs_line[31 - 8 * (j / 8) - 7 + (j % 8)] = cap_q[sz - 32 + j];
            check32("line_arp_fcs_bytes", fcs_line, 32'hF1FF3421);
        end
    endtask

    initial begin
        logic [7:0] arp [42];
        arp = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h98, 8'h5a, 8'heb, 8'hdd,
                8'h1c, 8'h64, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                8'h00, 8'h01, 8'h98, 8'h5a, 8'heb, 8'hdd, 8'h1c, 8'h64, 8'hc0, 8'ha8,
                8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h9d, 8'h37,
                8'heb, 8'h91};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 8'h00;

        // Reset state, then IDLE holds with no request.
        repeat (3) begin
            exp_q.push_back(5'b00000);
            tick();
        end
        reset = 1'b0;
        repeat (2) begin
            exp_q.push_back(5'b00000);
            tick();
        end

        // Short frame padded to minimum, followed back-to-back by the ARP request.
        fb = '{8'h41, 8'h42, 8'h43, 8'h44};
        run_frame(4, -1, -1, 576, 4, 0, 1'b1, 1'b0);
        fb.delete();
        for (int i = 0; i < 42; i++) fb.push_back(arp[i]);
        run_frame(42, -1, -1, 576, 42, 0, 1'b1, 1'b1);
        check32("b2b_idle_gap", last_gap, 97);

        // Long frame, no padding.
        fb.delete();
        for (int i = 0; i < 100; i++) fb.push_back(8'(i * 7 + 3));
        run_frame(100, -1, -1, 896, 100, 0, 1'b1, 1'b0);

        // Upstream underrun at byte 10.
        fb.delete();
        for (int i = 0; i < 20; i++) fb.push_back(8'(8'hA0 + i));
        run_frame(20, 10, -1, 144, 11, 1, 1'b0, 1'b0);

        // Reset pulse mid-DATA, then an exactly-minimum frame.
        fb.delete();
        for (int i = 0; i < 30; i++) fb.push_back(8'(i * 3));
        run_frame(30, -1, 107, 107, 6, 0, 1'b0, 1'b0);
        fb.delete();
        for (int i = 0; i < 60; i++) fb.push_back(8'(255 - i));
        run_frame(60, -1, -1, 576, 60, 0, 1'b1, 1'b0);

        tx_valid = 1'b0;
        repeat (3) begin
            exp_q.push_back(5'b00000);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
